// File: rtl/vdc_ramsched.sv
// Purpose: per-slot scheduler for the VDC video-RAM port (fetch > refresh > CPU/block FSM).
// Latency: all RAM outputs registered, 1 clk after the enable slot; read data captured 2 clk later.
// Backpressure: new CPU/block requests are dropped while busy; the CPU must poll busy.
// Ports: clk/reset (sync, active-high), enable slot strobe, fetch_req/addr/gnt display fetch,
//   line_start/reg_drr refresh, cpu_wr/cpu_rd/da_in R31 access, blk_start/wc_in/blk_copy block op,
//   ua_ld/ua_in and ba_ld/ba_in address loads, ram_* RAM port, ua/ba/da/wc/busy register views.
module vdc_ramsched #(
    parameter int RAM_ADDR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     fetch_req,
    input  logic [RAM_ADDR_BITS-1:0] fetch_addr,
    output logic                     fetch_gnt,
    input  logic                     line_start,
    input  logic [3:0]               reg_drr,
    input  logic                     cpu_wr,
    input  logic                     cpu_rd,
    input  logic [7:0]               da_in,
    input  logic                     blk_start,
    input  logic [7:0]               wc_in,
    input  logic                     blk_copy,
    input  logic                     ua_ld,
    input  logic [RAM_ADDR_BITS-1:0] ua_in,
    input  logic                     ba_ld,
    input  logic [RAM_ADDR_BITS-1:0] ba_in,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic                     ram_we,
    output logic                     ram_en,
    output logic [7:0]               ram_d,
    input  logic [7:0]               ram_q,
    output logic [RAM_ADDR_BITS-1:0] ua,
    output logic [RAM_ADDR_BITS-1:0] ba,
    output logic [7:0]               da,
    output logic [7:0]               wc,
    output logic                     busy
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_FILL, S_CRD, S_CWR} state_t;

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] ua_q, ua_d, ba_q, ba_d, addr_q, addr_d;
    logic [7:0]               da_q, da_d, wc_q, wc_d, rcnt_q, rcnt_d, dout_q, dout_d;
    logic [3:0]               rpend_q, rpend_d;
    logic                     en_q, en_d, we_q, we_d, gnt_q, gnt_d;
    // Read-return pipeline: cap1 = read issued last clk, cap2 = ram_q valid now.
    logic                     cap1_q, cap1_d, cap2_q, cap2_d;
    logic                     data_wait;

    // A copy write must not issue until the preceding read data has landed in da.
    assign data_wait = cap1_q | cap2_q;

    always_comb begin
        state_d = state_q;
        ua_d    = ua_q;
        ba_d    = ba_q;
        da_d    = da_q;
        wc_d    = wc_q;
        rcnt_d  = rcnt_q;
        rpend_d = rpend_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        gnt_d   = 1'b0;
        cap1_d  = 1'b0;
        cap2_d  = cap1_q;

        if (cap2_q) begin
            da_d = ram_q;
        end

        if (enable) begin
            if (fetch_req) begin
                en_d   = 1'b1;
                gnt_d  = 1'b1;
                addr_d = fetch_addr;
            end else if (rpend_q != 4'd0) begin
                en_d    = 1'b1;
                addr_d  = {{(RAM_ADDR_BITS-8){1'b0}}, rcnt_q};
                rcnt_d  = rcnt_q + 8'd1;
                rpend_d = rpend_q - 4'd1;
            end else begin
                case (state_q)
                    S_WR: begin
                        en_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ua_q;
                        dout_d  = da_q;
                        ua_d    = ua_q + 1'b1;
                        state_d = S_IDLE;
                    end
                    S_RD: begin
                        en_d    = 1'b1;
                        addr_d  = ua_q;
                        ua_d    = ua_q + 1'b1;
                        cap1_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    S_FILL: begin
                        en_d   = 1'b1;
                        we_d   = 1'b1;
                        addr_d = ua_q;
                        dout_d = da_q;
                        ua_d   = ua_q + 1'b1;
                        wc_d   = wc_q - 8'd1;
                        if (wc_q == 8'd1) begin
                            state_d = S_IDLE;
                        end
                    end
                    S_CRD: begin
                        en_d    = 1'b1;
                        addr_d  = ba_q;
                        ba_d    = ba_q + 1'b1;
                        cap1_d  = 1'b1;
                        state_d = S_CWR;
                    end
                    S_CWR: begin
                        if (!data_wait) begin
                            en_d    = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = ua_q;
                            dout_d  = da_q;
                            ua_d    = ua_q + 1'b1;
                            wc_d    = wc_q - 8'd1;
                            state_d = (wc_q == 8'd1) ? S_IDLE : S_CRD;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Accepting a request is independent of enable: the non-IDLE state is the pending flag.
        if (state_q == S_IDLE) begin
            if (cpu_wr) begin
                da_d    = da_in;
                state_d = S_WR;
            end else if (cpu_rd) begin
                state_d = S_RD;
            end else if (blk_start) begin
                wc_d    = wc_in;
                state_d = blk_copy ? S_CRD : S_FILL;
            end
        end

        if (line_start) begin
            rpend_d = reg_drr;
        end
        if (ua_ld) begin
            ua_d = ua_in;
        end
        if (ba_ld) begin
            ba_d = ba_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ua_q    <= '0;
            ba_q    <= '0;
            da_q    <= '0;
            wc_q    <= '0;
            rcnt_q  <= '0;
            rpend_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            gnt_q   <= 1'b0;
            cap1_q  <= 1'b0;
            cap2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ua_q    <= ua_d;
            ba_q    <= ba_d;
            da_q    <= da_d;
            wc_q    <= wc_d;
            rcnt_q  <= rcnt_d;
            rpend_q <= rpend_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_we    = we_q;
    assign ram_en    = en_q;
    assign ram_d     = dout_q;
    assign fetch_gnt = gnt_q;
    assign ua        = ua_q;
    assign ba        = ba_q;
    assign da        = da_q;
    assign wc        = wc_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vdc_ramsched.sv
// Purpose: self-checking bench for vdc_ramsched with a RAM model and an access scoreboard.
// Latency: expected RAM accesses are queued at stimulus time and compared as ram_en appears.
// Backpressure: every wait is cycle-bounded; an expired bound counts as an error.
module tb_vdc_ramsched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_gnt;
    logic        line_start = 1'b0;
    logic [3:0]  reg_drr = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  da_in = '0;
    logic        blk_start = 1'b0;
    logic [7:0]  wc_in = '0;
    logic        blk_copy = 1'b0;
    logic        ua_ld = 1'b0;
    logic [15:0] ua_in = '0;
    logic        ba_ld = 1'b0;
    logic [15:0] ba_in = '0;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic        ram_en;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
    logic [15:0] ua, ba;
    logic [7:0]  da, wc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  d;
    } acc_t;

    acc_t        sbq[$];
    acc_t        mon_e;
    logic        sb_on = 1'b1;
    logic [7:0]  rcnt_m = '0;

    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_dat = '0;

    vdc_ramsched #(.RAM_ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .line_start(line_start), .reg_drr(reg_drr),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .da_in(da_in),
        .blk_start(blk_start), .wc_in(wc_in), .blk_copy(blk_copy),
        .ua_ld(ua_ld), .ua_in(ua_in), .ba_ld(ba_ld), .ba_in(ba_in),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_en(ram_en), .ram_d(ram_d), .ram_q(ram_q),
        .ua(ua), .ba(ba), .da(da), .wc(wc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the clk after ram_en.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_d;
            else        ram_q <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (sb_on && ram_en) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got gnt=%0b we=%0b addr=%h d=%h, required no access",
                         fetch_gnt, ram_we, ram_addr, ram_d);
            end else begin
                mon_e = sbq.pop_front();
                if ({fetch_gnt, ram_we, ram_addr} !== {mon_e.gnt, mon_e.we, mon_e.addr} ||
                    (mon_e.we && ram_d !== mon_e.d)) begin
                    errors++;
                    $display("FAIL sb_access: got gnt=%0b we=%0b addr=%h d=%h, required gnt=%0b we=%0b addr=%h d=%h",
                             fetch_gnt, ram_we, ram_addr, ram_d, mon_e.gnt, mon_e.we, mon_e.addr, mon_e.d);
                end
            end
        end
    end

    task automatic push(input logic g, input logic w, input logic [15:0] a, input logic [7:0] d);
        acc_t e;
        e.gnt = g; e.we = w; e.addr = a; e.d = d;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_ua(input logic [15:0] a);
        @(negedge clk); ua_ld = 1'b1; ua_in = a;
        @(negedge clk); ua_ld = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk); pre_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_d, fetch_gnt, ua, ba, da, wc, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: got en=%0b we=%0b addr=%h d=%h gnt=%0b ua=%h ba=%h da=%h wc=%h busy=%0b, required all 0",
                     ram_en, ram_we, ram_addr, ram_d, fetch_gnt, ua, ba, da, wc, busy);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_write;
        bit ok;
        enable = 1'b0;
        load_ua(16'h1000);
        cpu_wr = 1'b1; da_in = 8'h5A;
        push(1'b0, 1'b1, 16'h1000, 8'h5A);
        @(negedge clk); cpu_wr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_set: got %0b required 1", busy); end
        enable = 1'b1;
        drain(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout: got pending=%0d required 0", sbq.size()); end
        checks++;
        if (ua !== 16'h1001) begin errors++; $display("FAIL write_ua: got %h required 1001", ua); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_clr: got %0b required 0", busy); end
    endtask

    task automatic test_fill;
        bit ok;
        load_ua(16'h1FFF);
        @(negedge clk); cpu_wr = 1'b1; da_in = 8'h20;
        push(1'b0, 1'b1, 16'h1FFF, 8'h20);
        @(negedge clk); cpu_wr = 1'b0;
        drain(50, ok);
        blk_copy = 1'b0; blk_start = 1'b1; wc_in = 8'd3;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 16'h2000 + 16'(i), 8'h20);
        @(negedge clk); blk_start = 1'b0;
        drain(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fill_timeout: got pending=%0d required 0", sbq.size()); end
        checks++;
        if ({ua, wc} !== {16'h2003, 8'h00}) begin
            errors++; $display("FAIL fill_regs: got ua=%h wc=%h required ua=2003 wc=00", ua, wc);
        end
    endtask

    task automatic test_copy;
        bit ok;
        preload(16'h0100, 8'h11);
        preload(16'h0101, 8'h22);
        @(negedge clk); ba_ld = 1'b1; ba_in = 16'h0100; ua_ld = 1'b1; ua_in = 16'h0200;
        @(negedge clk); ba_ld = 1'b0; ua_ld = 1'b0;
        blk_copy = 1'b1; blk_start = 1'b1; wc_in = 8'd2;
        push(1'b0, 1'b0, 16'h0100, 8'h00);
        push(1'b0, 1'b1, 16'h0200, 8'h11);
        push(1'b0, 1'b0, 16'h0101, 8'h00);
        push(1'b0, 1'b1, 16'h0201, 8'h22);
        @(negedge clk); blk_start = 1'b0; blk_copy = 1'b0;
        drain(60, ok);
        tick(2);
        checks++;
        if (!ok) begin errors++; $display("FAIL copy_timeout: got pending=%0d required 0", sbq.size()); end
        checks++;
        if ({mem[16'h0200], mem[16'h0201]} !== 16'h1122) begin
            errors++; $display("FAIL copy_mem: got %h %h required 11 22", mem[16'h0200], mem[16'h0201]);
        end
        checks++;
        if ({ba, ua, wc} !== {16'h0102, 16'h0202, 8'h00}) begin
            errors++; $display("FAIL copy_regs: got ba=%h ua=%h wc=%h required 0102 0202 00", ba, ua, wc);
        end
    endtask

    task automatic test_read;
        bit ok;
        preload(16'h4000, 8'hA5);
        load_ua(16'h4000);
        cpu_rd = 1'b1;
        push(1'b0, 1'b0, 16'h4000, 8'h00);
        @(negedge clk); cpu_rd = 1'b0;
        drain(50, ok);
        tick(3);
        checks++;
        if (!ok || da !== 8'hA5 || ua !== 16'h4001) begin
            errors++; $display("FAIL read_da: got ok=%0b da=%h ua=%h required ok=1 da=a5 ua=4001", ok, da, ua);
        end
    endtask

    task automatic test_fetch_stall;
        bit ok;
        enable = 1'b0;
        load_ua(16'h3000);
        blk_copy = 1'b0; blk_start = 1'b1; wc_in = 8'd4;
        @(negedge clk); blk_start = 1'b0;
        // Arrives while busy: must be dropped without touching da.
        cpu_wr = 1'b1; da_in = 8'hEE;
        @(negedge clk); cpu_wr = 1'b0;
        enable = 1'b1;
        push(1'b0, 1'b1, 16'h3000, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            fetch_req = 1'b1; fetch_addr = 16'h8000 + 16'(i);
            push(1'b1, 1'b0, fetch_addr, 8'h00);
        end
        @(negedge clk); fetch_req = 1'b0;
        for (int i = 1; i < 4; i++) push(1'b0, 1'b1, 16'h3000 + 16'(i), 8'hA5);
        drain(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fetch_timeout: got pending=%0d required 0", sbq.size()); end
        checks++;
        if ({da, ua, wc} !== {8'hA5, 16'h3004, 8'h00}) begin
            errors++; $display("FAIL fetch_regs: got da=%h ua=%h wc=%h required a5 3004 00", da, ua, wc);
        end
    endtask

    task automatic test_refresh;
        bit ok;
        enable = 1'b0;
        load_ua(16'h5000);
        @(negedge clk);
        line_start = 1'b1; reg_drr = 4'd5; cpu_wr = 1'b1; da_in = 8'h77;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 1'b0, {8'h00, rcnt_m}, 8'h00);
            rcnt_m = rcnt_m + 8'd1;
        end
        push(1'b0, 1'b1, 16'h5000, 8'h77);
        @(negedge clk); line_start = 1'b0; cpu_wr = 1'b0;
        enable = 1'b1;
        drain(60, ok);
        checks++;
        if (!ok || da !== 8'h77) begin
            errors++; $display("FAIL refresh_order: got ok=%0b da=%h required ok=1 da=77", ok, da);
        end
    endtask

    task automatic test_wrap_reset;
        int n, bad, after;
        sb_on = 1'b0;
        enable = 1'b0;
        load_ua(16'hFFFF);
        blk_copy = 1'b0; blk_start = 1'b1; wc_in = 8'd0;
        @(negedge clk); blk_start = 1'b0; enable = 1'b1;
        n = 0; bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ram_en) begin
                if (!ram_we || ram_addr !== 16'hFFFF + 16'(n) || ram_d !== 8'h77) bad++;
                n++;
            end
            if (!busy && !ram_en && n > 0) break;
        end
        checks++;
        if (n != 256 || bad != 0) begin
            errors++; $display("FAIL wrap_count: got writes=%0d bad=%0d required 256 0", n, bad);
        end
        checks++;
        if ({ua, wc} !== {16'h00FF, 8'h00}) begin
            errors++; $display("FAIL wrap_ua: got ua=%h wc=%h required 00ff 00", ua, wc);
        end

        load_ua(16'hFFFF);
        blk_start = 1'b1; wc_in = 8'd0;
        @(negedge clk); blk_start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000 && n < 100; i++) begin
            @(negedge clk);
            if (ram_en && ram_we) n++;
        end
        reset = 1'b1;
        after = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ram_en) after++;
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ram_en) after++;
        end
        checks++;
        if (n != 100 || after != 0) begin
            errors++; $display("FAIL reset_abort: got before=%0d after=%0d required 100 0", n, after);
        end
        checks++;
        if ({busy, ua, wc} !== '0) begin
            errors++; $display("FAIL reset_abort_regs: got busy=%0b ua=%h wc=%h required 0", busy, ua, wc);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_fill();
        test_copy();
        test_read();
        test_fetch_stall();
        test_refresh();
        test_wrap_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
